wb_select_stage: RTL and testbench

Parametrised writeback-select stage for the pipeline's final stage. It picks one of NSRC candidate results (ALU result, immediate, load data, link address, …) by selector and registers the chosen value with its destination register and write enable. It supports stall and flush, and keeps a small retirement history that answers forwarding lookups. It sits between the MA/WB pipeline register and the register file.

---
 rtl/wb_select_stage.sv | 126 ++++++++++++
 tb/tb_wb_select_stage.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_select_stage.sv
// Writeback-select stage: picks one of NSRC results, registers it with its destination and
// write enable, and (with WB_FWD_EN defined) keeps a retirement history for forwarding lookups.
module wb_select_stage #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 4,
  parameter int SELW  = 2,
  parameter int ADDRW = 5,
  parameter int HIST  = 2
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    ValidIn,
  input  logic                    StallIn,
  input  logic                    FlushIn,
  input  logic [NSRC*WIDTH-1:0]   SrcIn,
  input  logic [SELW-1:0]         SelectorIn,
  input  logic                    RegWriteIn,
  input  logic [ADDRW-1:0]        RegAddrIn,
  output logic [WIDTH-1:0]        DataOut,
  output logic [ADDRW-1:0]        RegAddrOut,
  output logic                    RegWriteOut,
  output logic                    ValidOut,
  input  logic [ADDRW-1:0]        FwdAddrIn,
  output logic                    FwdHitOut,
  output logic [WIDTH-1:0]        FwdDataOut
);

  // Out-of-range selectors saturate to the last source.
  function automatic logic [WIDTH-1:0] pick_src(input logic [NSRC*WIDTH-1:0] srcs,
                                                input logic [SELW-1:0] sel);
    int k;
    k = (int'(sel) >= NSRC) ? NSRC - 1 : int'(sel);
    return srcs[k*WIDTH +: WIDTH];
  endfunction

  logic [WIDTH-1:0] sel_data_p0;
  logic [WIDTH-1:0] data_p1;
  logic [ADDRW-1:0] addr_p1;
  logic             wr_p1;
  logic             vld_p1;

  assign sel_data_p0 = pick_src(SrcIn, SelectorIn);

  // p0 -> p1: capture stage; flush only kills the qualifiers, data/address hold.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      data_p1 <= '0;
      addr_p1 <= '0;
      wr_p1   <= 1'b0;
      vld_p1  <= 1'b0;
    end else if (FlushIn) begin
      wr_p1   <= 1'b0;
      vld_p1  <= 1'b0;
    end else if (!StallIn) begin
      data_p1 <= sel_data_p0;
      addr_p1 <= RegAddrIn;
      wr_p1   <= ValidIn & RegWriteIn & (RegAddrIn != '0);
      vld_p1  <= ValidIn;
    end
  end

  assign DataOut     = data_p1;
  assign RegAddrOut  = addr_p1;
  assign RegWriteOut = wr_p1;
  assign ValidOut    = vld_p1;

`ifdef WB_FWD_EN
  localparam int PTRW = (HIST > 1) ? $clog2(HIST) : 1;

  logic [ADDRW-1:0] hist_addr [HIST];
  logic [WIDTH-1:0] hist_data [HIST];
  logic [HIST-1:0]  hist_vld;
  logic [PTRW-1:0]  wptr;
  logic             push;

  // Slot holding the entry written 'age' pushes ago (age 0 = newest).
  function automatic logic [PTRW-1:0] age_idx(input logic [PTRW-1:0] p, input int age);
    int i;
    i = (int'(p) + HIST - 1 - age) % HIST;
    return PTRW'(i);
  endfunction

  assign push = (FlushIn || !StallIn) && vld_p1 && wr_p1;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hist_vld <= '0;
      wptr     <= '0;
    end else if (push) begin
      hist_vld[wptr] <= 1'b1;
      wptr           <= (wptr == PTRW'(HIST - 1)) ? '0 : wptr + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      hist_addr[wptr] <= addr_p1;
      hist_data[wptr] <= data_p1;
    end
  end

  // Oldest first so the newest match, and finally the output register, override.
  always_comb begin
    FwdHitOut  = 1'b0;
    FwdDataOut = '0;
    if (FwdAddrIn != '0) begin
      for (int a = HIST - 1; a >= 0; a--) begin
        if (hist_vld[age_idx(wptr, a)] && hist_addr[age_idx(wptr, a)] == FwdAddrIn) begin
          FwdHitOut  = 1'b1;
          FwdDataOut = hist_data[age_idx(wptr, a)];
        end
      end
      if (vld_p1 && wr_p1 && addr_p1 == FwdAddrIn) begin
        FwdHitOut  = 1'b1;
        FwdDataOut = data_p1;
      end
    end
  end
`else
  logic unused_fwd_addr;
  assign unused_fwd_addr = ^FwdAddrIn;
  assign FwdHitOut       = 1'b0;
  assign FwdDataOut      = '0;
`endif

endmodule

// File: tb/tb_wb_select_stage.sv
// Randomized self-checking bench for wb_select_stage against a queue-based reference model.
module tb_wb_select_stage;
  localparam int WIDTH = 32, NSRC = 4, SELW = 2, ADDRW = 5, HIST = 2;
`ifdef WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Reset, ValidIn, StallIn, FlushIn, RegWriteIn;
  logic [WIDTH-1:0] src [NSRC];
  logic [NSRC*WIDTH-1:0] SrcIn;
  logic [SELW-1:0] SelectorIn;
  logic [ADDRW-1:0] RegAddrIn, FwdAddrIn;
  logic [WIDTH-1:0] DataOut, FwdDataOut;
  logic [ADDRW-1:0] RegAddrOut;
  logic RegWriteOut, ValidOut, FwdHitOut;
  logic [WIDTH-1:0] d3_data, d3_fdata;
  logic [ADDRW-1:0] d3_addr;
  logic d3_wr, d3_vld, d3_hit;

  assign SrcIn = {src[3], src[2], src[1], src[0]};
  always #5 Clk = ~Clk;

  wb_select_stage #(.WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW), .ADDRW(ADDRW), .HIST(HIST)) dut (
    .Clk(Clk), .Reset(Reset), .ValidIn(ValidIn), .StallIn(StallIn), .FlushIn(FlushIn),
    .SrcIn(SrcIn), .SelectorIn(SelectorIn), .RegWriteIn(RegWriteIn), .RegAddrIn(RegAddrIn),
    .DataOut(DataOut), .RegAddrOut(RegAddrOut), .RegWriteOut(RegWriteOut), .ValidOut(ValidOut),
    .FwdAddrIn(FwdAddrIn), .FwdHitOut(FwdHitOut), .FwdDataOut(FwdDataOut));

  wb_select_stage #(.WIDTH(WIDTH), .NSRC(3), .SELW(SELW), .ADDRW(ADDRW), .HIST(HIST)) dut3 (
    .Clk(Clk), .Reset(Reset), .ValidIn(ValidIn), .StallIn(StallIn), .FlushIn(FlushIn),
    .SrcIn(SrcIn[3*WIDTH-1:0]), .SelectorIn(SelectorIn), .RegWriteIn(RegWriteIn),
    .RegAddrIn(RegAddrIn), .DataOut(d3_data), .RegAddrOut(d3_addr), .RegWriteOut(d3_wr),
    .ValidOut(d3_vld), .FwdAddrIn(FwdAddrIn), .FwdHitOut(d3_hit), .FwdDataOut(d3_fdata));

  int checks = 0;
  int errors = 0;

  // Reference model: the output beat plus a list of retired writes, oldest at the front.
  logic [WIDTH-1:0] m_data;
  logic [ADDRW-1:0] m_addr;
  logic m_wr, m_vld, m_dc;
  logic [ADDRW+WIDTH-1:0] hist_q [$];

  task automatic model_clear();
    m_data = '0; m_addr = '0; m_wr = 1'b0; m_vld = 1'b0; m_dc = 1'b0;
    hist_q.delete();
  endtask

  task automatic model_edge();
    int s;
    if ((!StallIn || FlushIn) && m_vld && m_wr) begin
      hist_q.push_back({m_addr, m_data});
      if (hist_q.size() > HIST) void'(hist_q.pop_front());
    end
    if (FlushIn) begin
      m_vld = 1'b0; m_wr = 1'b0; m_dc = 1'b1;
    end else if (!StallIn) begin
      s = (int'(SelectorIn) >= NSRC) ? NSRC - 1 : int'(SelectorIn);
      m_data = src[s]; m_addr = RegAddrIn; m_vld = ValidIn; m_dc = 1'b0;
      m_wr = ValidIn && RegWriteIn && (RegAddrIn != 0);
    end
  endtask

  function automatic logic [WIDTH:0] ref_lookup(input logic [ADDRW-1:0] a);
    if (!FWD || a == 0) return '0;
    if (m_vld && m_wr && m_addr == a) return {1'b1, m_data};
    for (int i = hist_q.size() - 1; i >= 0; i--)
      if (hist_q[i][ADDRW+WIDTH-1:WIDTH] == a) return {1'b1, hist_q[i][WIDTH-1:0]};
    return '0;
  endfunction

  task automatic drive(input logic v, input logic w, input logic [ADDRW-1:0] a,
                       input logic [SELW-1:0] s, input logic st, input logic fl);
    ValidIn = v; RegWriteIn = w; RegAddrIn = a; SelectorIn = s; StallIn = st; FlushIn = fl;
  endtask

  task automatic tick();
    model_edge();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < NSRC; k++) src[k] = '0;
    FwdAddrIn = 5'd5;
    model_clear();
    @(posedge Clk); #1;
    checks++;
    if ({DataOut, RegAddrOut, RegWriteOut, ValidOut, FwdHitOut, FwdDataOut} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got data=%h addr=%0d wr=%b vld=%b hit=%b fdata=%h, want all 0",
               DataOut, RegAddrOut, RegWriteOut, ValidOut, FwdHitOut, FwdDataOut);
    end
    Reset = 1'b0;
    #1;
  endtask

  task automatic test_basic();
    src[0] = 32'h1111_1111; src[1] = 32'h2222_2222; src[2] = 32'h3333_3333; src[3] = 32'h4444_4444;
    drive(1, 1, 5'd5, 2'd2, 0, 0);
    tick();
    checks++;
    if ({DataOut, RegAddrOut, RegWriteOut, ValidOut} !== {32'h3333_3333, 5'd5, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL basic_capture got %h/%0d/%b/%b want 33333333/5/1/1",
               DataOut, RegAddrOut, RegWriteOut, ValidOut);
    end
    FwdAddrIn = 5'd5; #1;
    checks++;
    if ({FwdHitOut, FwdDataOut} !== {FWD, FWD ? 32'h3333_3333 : 32'h0}) begin
      errors++;
      $display("FAIL basic_fwd_outreg got hit=%b data=%h want hit=%b", FwdHitOut, FwdDataOut, FWD);
    end
  endtask

  task automatic test_sel_clamp();
    for (int k = 0; k < NSRC; k++) src[k] = $urandom;
    drive(1, 0, 5'd9, 2'd3, 0, 0);
    tick();
    checks++;
    if (d3_data !== src[2]) begin
      errors++;
      $display("FAIL sel_clamp_nsrc3 got %h want %h", d3_data, src[2]);
    end
    checks++;
    if (DataOut !== src[3]) begin
      errors++;
      $display("FAIL sel3_nsrc4 got %h want %h", DataOut, src[3]);
    end
  endtask

  task automatic test_addr0();
    drive(1, 1, 5'd0, 2'd0, 0, 0);
    tick();
    checks++;
    if ({RegWriteOut, ValidOut} !== 2'b01) begin
      errors++;
      $display("FAIL addr0_write got wr=%b vld=%b want wr=0 vld=1", RegWriteOut, ValidOut);
    end
    FwdAddrIn = 5'd0; #1;
    checks++;
    if (FwdHitOut !== 1'b0) begin
      errors++;
      $display("FAIL addr0_lookup got hit=%b want 0", FwdHitOut);
    end
  endtask

  task automatic test_stall();
    logic [WIDTH+ADDRW+1:0] snap;
    logic [WIDTH:0] exp;
    src[1] = 32'hCAFE_0001;
    drive(1, 1, 5'd6, 2'd1, 0, 0);
    tick();
    snap = {DataOut, RegAddrOut, RegWriteOut, ValidOut};
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < NSRC; k++) src[k] = $urandom;
      drive(1, 1, 5'(7 - c), 2'(c), 1, 0);
      tick();
      checks++;
      if ({DataOut, RegAddrOut, RegWriteOut, ValidOut} !== snap ||
          snap !== {32'hCAFE_0001, 5'd6, 1'b1, 1'b1}) begin
        errors++;
        $display("FAIL stall_hold c=%0d got %h want %h", c, {DataOut, RegAddrOut, RegWriteOut, ValidOut}, snap);
      end
      FwdAddrIn = 5'd5; #1;
      exp = ref_lookup(5'd5);
      checks++;
      if ({FwdHitOut, FwdDataOut} !== exp) begin
        errors++;
        $display("FAIL stall_hist_r5 c=%0d got %b/%h want %b/%h", c, FwdHitOut, FwdDataOut, exp[WIDTH], exp[WIDTH-1:0]);
      end
    end
    drive(1, 1, 5'd8, 2'd0, 1, 1);
    tick();
    checks++;
    if ({ValidOut, RegWriteOut} !== 2'b00) begin
      errors++;
      $display("FAIL flush_over_stall got vld=%b wr=%b want 0/0", ValidOut, RegWriteOut);
    end
  endtask

  task automatic test_history();
    logic [WIDTH-1:0] wd [4];
    logic [ADDRW-1:0] wa [4];
    wd = '{32'hA, 32'hB, 32'hC, 32'hD};
    wa = '{5'd3, 5'd4, 5'd3, 5'd7};
    Reset = 1'b1; model_clear(); #1; Reset = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      src[0] = wd[i];
      drive(1, 1, wa[i], 2'd0, 0, 0);
      tick();
    end
    drive(1, 0, 5'd1, 2'd0, 0, 0);
    tick();
    FwdAddrIn = 5'd3; #1;
    checks++;
    if ({FwdHitOut, FwdDataOut} !== {FWD, FWD ? 32'hC : 32'h0}) begin
      errors++;
      $display("FAIL hist_r3_newest got %b/%h want %b/%h", FwdHitOut, FwdDataOut, FWD, FWD ? 32'hC : 32'h0);
    end
    FwdAddrIn = 5'd4; #1;
    checks++;
    if ({FwdHitOut, FwdDataOut} !== {FWD, FWD ? 32'hB : 32'h0}) begin
      errors++;
      $display("FAIL hist_r4 got %b/%h want %b/%h", FwdHitOut, FwdDataOut, FWD, FWD ? 32'hB : 32'h0);
    end
    src[0] = wd[3];
    drive(1, 1, wa[3], 2'd0, 0, 0);
    tick();
    drive(0, 0, 5'd0, 2'd0, 0, 0);
    tick();
    FwdAddrIn = 5'd4; #1;
    checks++;
    if (FwdHitOut !== 1'b0) begin
      errors++;
      $display("FAIL hist_wrap_r4_evicted got hit=%b want 0", FwdHitOut);
    end
    FwdAddrIn = 5'd7; #1;
    checks++;
    if ({FwdHitOut, FwdDataOut} !== {FWD, FWD ? 32'hD : 32'h0}) begin
      errors++;
      $display("FAIL hist_r7 got %b/%h want %b/%h", FwdHitOut, FwdDataOut, FWD, FWD ? 32'hD : 32'h0);
    end
  endtask

  task automatic test_random();
    logic [WIDTH:0] exp;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NSRC; k++) src[k] = $urandom;
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)),
            2'($urandom_range(0, 3)), $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
      tick();
      checks++;
      if ({RegWriteOut, ValidOut} !== {m_wr, m_vld}) begin
        errors++;
        $display("FAIL rand_ctrl c=%0d got wr=%b vld=%b want %b/%b", c, RegWriteOut, ValidOut, m_wr, m_vld);
      end
      if (!m_dc) begin
        checks++;
        if ({DataOut, RegAddrOut} !== {m_data, m_addr}) begin
          errors++;
          $display("FAIL rand_data c=%0d got %h/%0d want %h/%0d", c, DataOut, RegAddrOut, m_data, m_addr);
        end
      end
      FwdAddrIn = 5'($urandom_range(0, 7)); #1;
      exp = ref_lookup(FwdAddrIn);
      checks++;
      if ({FwdHitOut, FwdDataOut} !== exp) begin
        errors++;
        $display("FAIL rand_fwd c=%0d a=%0d got %b/%h want %b/%h", c, FwdAddrIn, FwdHitOut, FwdDataOut, exp[WIDTH], exp[WIDTH-1:0]);
      end
    end
  endtask

  task automatic test_async_reset();
    src[2] = 32'h5A5A_5A5A;
    drive(1, 1, 5'd6, 2'd2, 0, 0);
    tick();
    drive(1, 1, 5'd2, 2'd2, 0, 0);
    tick();
    FwdAddrIn = 5'd6;
    #1 Reset = 1'b1;
    #1;
    checks++;
    if ({DataOut, RegAddrOut, RegWriteOut, ValidOut, FwdHitOut, FwdDataOut} !== '0) begin
      errors++;
      $display("FAIL async_reset got data=%h addr=%0d wr=%b vld=%b hit=%b fdata=%h, want all 0",
               DataOut, RegAddrOut, RegWriteOut, ValidOut, FwdHitOut, FwdDataOut);
    end
    Reset = 1'b0;
    model_clear();
    #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sel_clamp();
    test_addr0();
    test_stall();
    test_history();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
